// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and helpers for the fetch-stage slice.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST        = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & INST_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for the in-flight PC queue and the instruction buffer.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (!push_ok && pop_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, issues in-order imem requests under a credit check,
// buffers returned words with their PC, and squashes stale responses after a redirect.
module if_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            if_id_enable
);

  localparam int OCW = $clog2(MAX_OUTST + 1);
  localparam int BCW = $clog2(BUF_DEPTH + 1);
  localparam int EW  = 2 * XLEN;

  logic [XLEN-1:0] fetch_pc;
  logic [OCW-1:0]  outst;
  logic [OCW-1:0]  drop_cnt;
  logic [OCW-1:0]  live_outst;
  logic            accept;
  logic            rsp_ok;
  logic            rsp_drop;
  logic            rsp_keep;

  logic [XLEN-1:0] pcq_head;
  logic [OCW-1:0]  pcq_count;
  logic            pcq_full;
  logic            pcq_empty;

  logic [EW-1:0]   buf_head;
  logic [BCW-1:0]  buf_count;
  logic            buf_full;
  logic            buf_empty;

  assign live_outst = outst - drop_cnt;

  // A request is only issued if its answer is guaranteed a buffer slot.
  assign imem_req_valid = rst_n & ~redirect_valid & ~pcq_full
                        & (32'(outst) < 32'(MAX_OUTST))
                        & ((32'(live_outst) + 32'(buf_count)) < 32'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rsp_ok   = imem_rsp_valid & (outst != '0);
  assign rsp_drop = rsp_ok & (redirect_valid | (drop_cnt != '0));
  assign rsp_keep = rsp_ok & ~rsp_drop & ~pcq_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
      outst    <= outst - OCW'(rsp_ok);
      drop_cnt <= outst - OCW'(rsp_ok);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      outst <= outst + OCW'(accept) - OCW'(rsp_ok);
      if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - OCW'(1);
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head      (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({pcq_head, imem_rsp_data}),
    .pop       (if_id_enable),
    .flush     (redirect_valid),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign inst_valid   = ~buf_empty;
  assign inst_out     = inst_valid ? buf_head[XLEN-1:0] : NOP_INST;
  assign inst_pc      = inst_valid ? buf_head[EW-1:XLEN] : '0;
  assign if_id_enable = inst_valid & id_ready & ~redirect_valid;

  a_rsp_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outst != '0));
  a_live_matches_pcq: assert property (@(posedge clk) disable iff (!rst_n)
    live_outst == pcq_count);
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_keep && buf_full) |-> if_id_enable);

endmodule
